// File: rtl/router_1xn.sv
// router_1xn: byte-serial packet input steered to one of N channel FIFOs by the header dest field.
// Latency: a written word raises vld_out on the next edge; data_out follows read_enb by one cycle.
// Backpressure: busy holds the source while the target FIFO is full or draining, and during the check cycle.

module router_1xn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             do_wr;
    logic             do_rd;

    // full/empty come from the registered occupancy, so a pop on a full FIFO
    // does not open a slot for a write in the same cycle. Flush beats both.
    assign full  = (occ == CNT_W'(DEPTH));
    assign empty = (occ == '0);
    assign do_wr = wr_en & ~full & ~flush;
    assign do_rd = rd_en & ~empty & ~flush;

    // Storage array; no reset needed because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers, occupancy and the registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            rd_dat <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                rd_dat <= mem[rd_ptr];
            end
            if (do_wr && !do_rd) begin
                occ <= occ + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                occ <= occ - CNT_W'(1);
            end
        end
    end
endmodule

// router_1xn: header-decoded 1-to-N packet router with parity/length check and per-channel read timeout.
// Latency: header lands in the channel FIFO on its acceptance edge; err/drop appear the cycle after the last word.
// Backpressure: busy=1 while the target FIFO is full, while waiting for it to drain, and in the check cycle.

module router_1xn #(
    parameter int WIDTH   = 8,
    parameter int N       = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [N-1:0]         read_enb,
    output logic                 busy,
    output logic [N-1:0]         vld_out,
    output logic [N*WIDTH-1:0]   data_out,
    output logic                 err,
    output logic                 drop
);
    localparam int ADDR_W = ($clog2(N) < 1) ? 1 : $clog2(N);
    localparam int LEN_W  = WIDTH - ADDR_W;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD,
        CHECK,
        DROP_PKT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic              dest_ok;

    logic [ADDR_W-1:0] dest_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  pcnt_q;
    logic [WIDTH-1:0]  hdr_q;
    logic [WIDTH-1:0]  par_q;
    logic [WIDTH-1:0]  rx_par_q;
    logic              drop_q;

    logic              accept;
    logic              abort;
    logic              drop_set;
    logic [N-1:0]      wr_en;
    logic [WIDTH-1:0]  wr_dat;
    logic [N-1:0]      full;
    logic [N-1:0]      empty;
    logic [N-1:0]      flush;

    assign hdr_dest = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[WIDTH-1:ADDR_W];
    assign dest_ok  = (hdr_dest <= ADDR_W'(N - 1));
    assign vld_out  = ~empty;
    assign drop     = drop_q;

    // A timeout flush on the channel being filled kills the rest of that packet.
    assign abort = ((state == LOAD) || (state == WAIT_EMPTY)) && flush[dest_q];

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_chan
            logic [TMO_W-1:0] tmo_q;

            // Flush fires on the edge after the idle count reaches TIMEOUT-1 with nobody reading.
            assign flush[i] = ~empty[i] & ~read_enb[i] & (tmo_q == TMO_W'(TIMEOUT - 1));

            // Idle-reader counter: runs while data waits unread, clears on read, empty or flush.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    tmo_q <= '0;
                end else if (flush[i] || empty[i] || read_enb[i]) begin
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end

            router_1xn_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clock  (clock),
                .reset  (reset),
                .wr_en  (wr_en[i]),
                .wr_dat (wr_dat),
                .rd_en  (read_enb[i]),
                .flush  (flush[i]),
                .rd_dat (data_out[i*WIDTH +: WIDTH]),
                .full   (full[i]),
                .empty  (empty[i])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, word acceptance, FIFO write steering, busy and err.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        drop_set  = 1'b0;
        wr_en     = '0;
        wr_dat    = data_in;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    accept = 1'b1;
                    if (!dest_ok) begin
                        state_nxt = DROP_PKT;
                    end else if (!empty[hdr_dest]) begin
                        // Previous packet still queued: hold this header until the channel drains.
                        state_nxt = WAIT_EMPTY;
                    end else begin
                        wr_en[hdr_dest] = 1'b1;
                        state_nxt       = LOAD;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = DROP_PKT;
                end else if (empty[dest_q]) begin
                    wr_en[dest_q] = 1'b1;
                    wr_dat        = hdr_q;
                    state_nxt     = LOAD;
                end
            end
            LOAD: begin
                busy = full[dest_q];
                if (!full[dest_q]) begin
                    accept        = 1'b1;
                    wr_en[dest_q] = 1'b1;
                    if (!pkt_valid) begin
                        state_nxt = CHECK;
                    end
                end
                if (abort) begin
                    // If the parity word is arriving right now the packet ends here;
                    // otherwise keep swallowing words until it does.
                    if (accept && !pkt_valid) begin
                        drop_set  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DROP_PKT;
                    end
                end
            end
            CHECK: begin
                busy      = 1'b1;
                err       = (rx_par_q != par_q) || (pcnt_q != len_q);
                state_nxt = IDLE;
            end
            DROP_PKT: begin
                accept = 1'b1;
                if (!pkt_valid) begin
                    drop_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Packet context: header fields, running parity, payload count, received parity, drop pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dest_q   <= '0;
            len_q    <= '0;
            pcnt_q   <= '0;
            hdr_q    <= '0;
            par_q    <= '0;
            rx_par_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= drop_set;
            if (state == IDLE && pkt_valid && dest_ok) begin
                dest_q <= hdr_dest;
                len_q  <= hdr_len;
                hdr_q  <= data_in;
                par_q  <= data_in;
                pcnt_q <= '0;
            end
            if (state == LOAD && accept) begin
                if (pkt_valid) begin
                    par_q  <= par_q ^ data_in;
                    pcnt_q <= pcnt_q + LEN_W'(1);
                end else begin
                    rx_par_q <= data_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed vectors against two router_1xn instances (DEPTH 16 and DEPTH 4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the send tasks hold each word until busy is low.

module tb_router_1xn;
    logic        clock;
    logic        reset;

    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic        busy;
    logic [2:0]  vld_out;
    logic [23:0] data_out;
    logic        err;
    logic        drop;

    logic        pkt_valid4;
    logic [7:0]  data_in4;
    logic [2:0]  read_enb4;
    logic        busy4;
    logic [2:0]  vld_out4;
    logic [23:0] data_out4;
    logic        err4;
    logic        drop4;

    int          n_vec;
    int          n_bad;
    int          cyc;
    int          h0;
    int          h2;
    logic [7:0]  expv [8];
    logic [7:0]  w4 [8];

    router_1xn #(.WIDTH(8), .N(3), .DEPTH(16), .TIMEOUT(30)) dut (
        .clock     (clock),
        .reset     (reset),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .read_enb  (read_enb),
        .busy      (busy),
        .vld_out   (vld_out),
        .data_out  (data_out),
        .err       (err),
        .drop      (drop)
    );

    router_1xn #(.WIDTH(8), .N(3), .DEPTH(4), .TIMEOUT(30)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .pkt_valid (pkt_valid4),
        .data_in   (data_in4),
        .read_enb  (read_enb4),
        .busy      (busy4),
        .vld_out   (vld_out4),
        .data_out  (data_out4),
        .err       (err4),
        .drop      (drop4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got hang want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        int guard;
        guard     = 0;
        pkt_valid = v;
        data_in   = d;
        while (busy && guard < 100) begin
            step(1);
            guard++;
        end
        if (guard >= 100) check("send_stall", 32'(busy), 32'h0);
        step(1);
    endtask

    task automatic send4(input logic v, input logic [7:0] d);
        int guard;
        guard      = 0;
        pkt_valid4 = v;
        data_in4   = d;
        while (busy4 && guard < 100) begin
            step(1);
            guard++;
        end
        if (guard >= 100) check("send4_stall", 32'(busy4), 32'h0);
        step(1);
    endtask

    // Reads k words from channel ch and compares them with expv[0..k-1].
    task automatic read_chan(input int ch, input int k);
        read_enb = 3'(1 << ch);
        for (int i = 0; i < k; i++) begin
            step(1);
            check("rd_data", 32'(data_out[ch*8 +: 8]), 32'(expv[i]));
        end
        read_enb = 3'b000;
        check("rd_drained", 32'(vld_out[ch]), 32'h0);
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        cyc        = 0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 3'b000;
        pkt_valid4 = 1'b0;
        data_in4   = 8'h00;
        read_enb4  = 3'b000;
        reset      = 1'b0;
        #3 reset = 1'b1;
        #20;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_vld", 32'(vld_out), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        step(1);

        // Good packet to channel 1: 0x0D (dest 1, len 3), parity 0x0D.
        send(1'b1, 8'h0D); send(1'b1, 8'h11); send(1'b1, 8'h22); send(1'b1, 8'h33); send(1'b0, 8'h0D);
        check("t1_err", 32'(err), 32'h0);
        check("t1_chk_busy", 32'(busy), 32'h1);
        check("t1_vld", 32'(vld_out), 32'h2);
        step(1);
        check("t1_idle_busy", 32'(busy), 32'h0);
        expv = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00};
        read_chan(1, 5);

        // Same packet with a bad parity word.
        send(1'b1, 8'h0D); send(1'b1, 8'h11); send(1'b1, 8'h22); send(1'b1, 8'h33); send(1'b0, 8'h00);
        check("t2_err_pulse", 32'(err), 32'h1);
        step(1);
        check("t2_err_clear", 32'(err), 32'h0);
        expv = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
        read_chan(1, 5);

        // Header to channel 3 (nonexistent), then a normal packet to channel 2.
        send(1'b1, 8'h03);
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_no_drop_yet", 32'(drop), 32'h0);
        send(1'b0, 8'h03);
        check("t3_drop", 32'(drop), 32'h1);
        check("t3_vld", 32'(vld_out), 32'h0);
        check("t3_busy_end", 32'(busy), 32'h0);
        step(1);
        check("t3_drop_clear", 32'(drop), 32'h0);
        send(1'b1, 8'h06); send(1'b1, 8'h5A); send(1'b0, 8'h5C);
        check("t3_next_err", 32'(err), 32'h0);
        check("t3_next_vld", 32'(vld_out), 32'h4);
        step(1);
        expv = '{8'h06, 8'h5A, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        read_chan(2, 3);

        // DEPTH=4 instance: 8-word packet (dest 1, len 6), parity 0x1E, reader starts late.
        w4 = '{8'h19, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1E};
        fork
            begin : sender4
                for (int i = 0; i < 8; i++) begin
                    send4(i < 7, w4[i]);
                end
                check("t4_err", 32'(err4), 32'h0);
                pkt_valid4 = 1'b0;
            end
            begin : reader4
                int n;
                int k;
                int g;
                logic pv;
                n = 0;
                while (!busy4 && n < 20) begin
                    step(1);
                    n++;
                end
                check("t4_busy_edge", 32'(n), 32'd4);
                step(2);
                check("t4_busy_hold", 32'(busy4), 32'h1);
                read_enb4 = 3'b010;
                k = 0;
                g = 0;
                while (k < 8 && g < 100) begin
                    pv = vld_out4[1];
                    step(1);
                    g++;
                    if (pv) begin
                        check("t4_data", 32'(data_out4[15:8]), 32'(w4[k]));
                        k++;
                    end
                end
                check("t4_count", 32'(k), 32'd8);
                read_enb4 = 3'b000;
            end
        join
        step(1);
        check("t4_vld_end", 32'(vld_out4), 32'h0);

        // Timeout: channel 0 then channel 2 left unread.
        send(1'b1, 8'h00);
        h0 = cyc;
        send(1'b0, 8'h00);
        send(1'b1, 8'h02);
        h2 = cyc;
        send(1'b0, 8'h02);
        pkt_valid = 1'b0;
        while (cyc < h0 + 29) step(1);
        check("t5_vld0_29", 32'(vld_out[0]), 32'h1);
        step(1);
        check("t5_vld0_30", 32'(vld_out[0]), 32'h0);
        check("t5_vld2_kept", 32'(vld_out[2]), 32'h1);
        while (cyc < h2 + 29) step(1);
        check("t5_vld2_29", 32'(vld_out[2]), 32'h1);
        step(1);
        check("t5_vld2_30", 32'(vld_out[2]), 32'h0);

        // Reset mid-LOAD, then a fresh packet to channel 0 (len 1), parity 0x73.
        send(1'b1, 8'h0D); send(1'b1, 8'h11);
        check("t6_pre_vld", 32'(vld_out), 32'h2);
        reset = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_vld", 32'(vld_out), 32'h0);
        check("t6_data", 32'(data_out), 32'h0);
        check("t6_err", 32'(err), 32'h0);
        check("t6_drop", 32'(drop), 32'h0);
        pkt_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        step(1);
        send(1'b1, 8'h04); send(1'b1, 8'h77); send(1'b0, 8'h73);
        check("t6_post_err", 32'(err), 32'h0);
        check("t6_post_vld", 32'(vld_out), 32'h1);
        step(1);
        expv = '{8'h04, 8'h77, 8'h73, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        read_chan(0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
Parametrised successor of the 1x3 packet router: one byte-serial input port feeds N output channels, each backed by its own DEPTH-entry FIFO. It decodes the destination from the header, streams the packet into the selected FIFO with busy back-pressure, and checks parity and length. Packets to nonexistent channels are dropped, and stalled output channels are flushed by a per-channel read timeout. Sits between the upstream packet source and N independent downstream readers.

Parameters:
WIDTH, 8, data word width; must exceed ADDR_W.
N, 3, number of output channels, 2..16.
DEPTH, 16, words per channel FIFO, power of two.
TIMEOUT, 30, idle cycles with vld_out high and no read before channel soft reset.
ADDR_W, derived, max(1, clog2(N)); not overridable.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
pkt_valid  in  1  high for header+payload words; falls on the parity word.
data_in  in  WIDTH  packet word.
read_enb  in  N  per-channel read strobe.
busy  out  1  source must hold data_in/pkt_valid while high.
vld_out  out  N  channel FIFO non-empty.
data_out  out  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
err  out  1  one-cycle pulse: parity or length mismatch.
drop  out  1  one-cycle pulse: packet discarded.

Behaviour:
- Reset: async, active-high. Forces FSM to IDLE; all FIFOs empty; timeout counters 0; busy, vld_out, data_out, err, drop = 0.
- Header format: dest = data_in[ADDR_W-1:0]; len = data_in[WIDTH-1:ADDR_W] payload words.
- Packet format: header, then len payload words, then a parity word equal to the XOR of header and payload.
- Word acceptance: a word is accepted on any edge where busy=0 and the FSM is in IDLE(pkt_valid=1), LOAD or DROP_PKT.
- IDLE (busy=0):
  - pkt_valid=1 and dest>=N -> DROP_PKT; header not written.
  - dest<N and vld_out[dest]=1 -> WAIT_EMPTY; header held, busy=1.
  - Otherwise write header to FIFO[dest] -> LOAD. Latch dest and len; running parity = header; payload count = 0.
- WAIT_EMPTY (busy=1): when FIFO[dest] empties, write header -> LOAD.
- LOAD (busy = full[dest]):
  - Accepted word with pkt_valid=1: write it; XOR into parity; count+1.
  - Accepted word with pkt_valid=0 (parity word): write it -> CHECK.
  - Writes are gated by full sampled at the start of the cycle. A simultaneous read on a full FIFO does not allow a same-cycle write.
- CHECK (busy=1, one cycle): err=1 if received parity != computed parity, or count != len. Then -> IDLE.
- DROP_PKT (busy=0): consume words until a word with pkt_valid=0 is accepted; pulse drop; -> IDLE. Nothing is written.
- FIFO: occupancy counter clog2(DEPTH+1) bits; pointers wrap modulo DEPTH; vld_out[i] = ~empty.
  - Read: read_enb[i] with vld_out[i]=1 pops a word; data_out slice updates on the next edge (1-cycle latency).
  - Reads while empty are ignored; data_out holds its value when not reading.
- Timeout: counter[i] increments each cycle that vld_out[i]=1 and read_enb[i]=0; it clears on read or empty.
  - When counter[i] reaches TIMEOUT-1 the FIFO is flushed on the next edge and the counter clears.
  - If i is the current LOAD/WAIT_EMPTY target, the FSM moves to DROP_PKT: the rest of the packet is discarded and drop pulses.
- Simultaneous timeout flush and write to the same FIFO: flush wins.
- Simultaneous read and write: both occur; occupancy is unchanged.

Test Plan:
- N=3, DEPTH=16: header 0x0D (dest 1, len 3), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33=0x0D. Expected: 5 words in FIFO1; vld_out=3'b010; err=0; reads return the same sequence with 1-cycle latency.
- Same packet with parity 0x00. Expected: err pulses exactly once, in the cycle after the parity word; the data is still stored.
- Header 0x03 (dest 3) with N=3. Expected: no FIFO writes; drop pulses once; busy stays 0; the next valid packet is routed normally.
- DEPTH=4, len=6, no reads. Expected: busy rises after the 4th write and data_in holds. Start reading 2 cycles later: busy drops and all 8 words arrive in order.
- Leave FIFO0 non-empty and unread for 30 cycles. Expected: vld_out[0] falls at cycle 30; other channels are unaffected.
- Assert reset mid-LOAD. Expected: all outputs 0 immediately; a post-reset packet routes correctly.
